// File: rtl/charset_fetch.sv
// charset_fetch: character ROM sequencer. Video pattern fetches have top priority; aux readback uses idle slots; drives the pixel shifter.
// Latency: video pattern reaches pend two clocks after vid_req; aux_ack rises two clocks after an aux read is issued.
// Backpressure: video never stalls; aux waits for a slot with no vid_req and an idle aux FSM (continuous video starves aux).
module charset_fetch #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          vid_req,
    input  logic [7:0]    vid_code,
    input  logic [2:0]    vid_row,
    input  logic [1:0]    vid_bank,
    input  logic          vid_inv,
    input  logic          vid_load,
    output logic          pixel,
    output logic          underrun,
    input  logic          aux_req,
    input  logic [AW-1:0] aux_addr,
    output logic          aux_ack,
    output logic [DW-1:0] aux_data,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q
);

    // Owner of the ROM slot that is currently in flight.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_AUX  = 2'd2
    } tag_t;

    // Aux read port handshake state.
    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_WAIT = 2'd1,
        A_ACK  = 2'd2
    } aux_state_t;

    aux_state_t    aux_state;
    aux_state_t    aux_state_nxt;

    // tag1: slot whose address is on rom_addr now; tag2: slot whose data is on rom_q now.
    tag_t          tag1;
    tag_t          tag2;
    logic          inv1;
    logic          inv2;

    logic [DW-1:0] pend;
    logic          pend_valid;
    logic [DW-1:0] sr;

    logic [AW-1:0] vid_addr;
    logic          aux_issue;
    logic          vid_capture;
    logic          aux_capture;
    logic          load_now;
    logic [DW-1:0] vid_pattern;

    assign vid_addr    = AW'({vid_bank, vid_code, vid_row});
    assign pixel       = sr[DW-1];

    // Slot arbitration and pipeline decode; video always wins the issue slot.
    always_comb begin
        aux_issue   = 1'b0;
        vid_capture = 1'b0;
        aux_capture = 1'b0;
        load_now    = 1'b0;
        vid_pattern = '0;
        aux_issue   = !vid_req && (aux_state == A_IDLE) && aux_req;
        vid_capture = (tag2 == TAG_VID);
        aux_capture = (tag2 == TAG_AUX);
        load_now    = ce && vid_load;
        vid_pattern = rom_q ^ {DW{inv2}};
    end

    // Aux FSM next state: the ack cycle is a dead cycle so a held request re-arms one clock later.
    always_comb begin
        aux_state_nxt = aux_state;
        case (aux_state)
            A_IDLE:  if (aux_issue)   aux_state_nxt = A_WAIT;
            A_WAIT:  if (aux_capture) aux_state_nxt = A_ACK;
            A_ACK:   aux_state_nxt = A_IDLE;
            default: aux_state_nxt = A_IDLE;
        endcase
    end

    // Aux FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aux_state <= A_IDLE;
        end else begin
            aux_state <= aux_state_nxt;
        end
    end

    // Issue stage: load the ROM address for the winner of this slot and tag it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_addr <= '0;
            tag1     <= TAG_NONE;
            inv1     <= 1'b0;
        end else if (vid_req) begin
            rom_addr <= vid_addr;
            tag1     <= TAG_VID;
            inv1     <= vid_inv;
        end else if (aux_issue) begin
            rom_addr <= aux_addr;
            tag1     <= TAG_AUX;
            inv1     <= 1'b0;
        end else begin
            tag1     <= TAG_NONE;
            inv1     <= 1'b0;
        end
    end

    // Follow the ROM's one-clock read latency so the tag lines up with rom_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag2 <= TAG_NONE;
            inv2 <= 1'b0;
        end else begin
            tag2 <= tag1;
            inv2 <= inv1;
        end
    end

    // Aux result capture; aux_ack pulses for exactly the cycle after the data lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aux_ack  <= 1'b0;
            aux_data <= '0;
        end else begin
            aux_ack <= aux_capture;
            if (aux_capture) begin
                aux_data <= rom_q;
            end
        end
    end

    // Pending video pattern; a newer capture silently replaces an unconsumed one,
    // and a capture coinciding with a load bypasses straight to the shifter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (vid_capture) begin
                pend <= vid_pattern;
            end
            if (load_now) begin
                pend_valid <= 1'b0;
            end else if (vid_capture) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // Pixel shifter: load on ce+vid_load (bypass, pending, or zero on underrun), else shift left on ce.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (ce) begin
            if (vid_load) begin
                if (vid_capture) begin
                    sr <= vid_pattern;
                end else if (pend_valid) begin
                    sr <= pend;
                end else begin
                    sr <= '0;
                end
            end else begin
                sr <= {sr[DW-2:0], 1'b0};
            end
        end
    end

    // Sticky underrun: a load found neither a pending nor a bypassing pattern.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (load_now && !vid_capture && !pend_valid) begin
            underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_charset_fetch.sv
// tb_charset_fetch: directed + randomized bench for charset_fetch against a transaction-level model.
// Latency: model schedules each video pattern and aux ack two edges after issue.
// Backpressure: aux requests are held until ack, as the port requires.
module tb_charset_fetch;
    localparam int AW = 13;
    localparam int DW = 8;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          ce       = 1'b0;
    logic          vid_req  = 1'b0;
    logic [7:0]    vid_code = '0;
    logic [2:0]    vid_row  = '0;
    logic [1:0]    vid_bank = '0;
    logic          vid_inv  = 1'b0;
    logic          vid_load = 1'b0;
    logic          aux_req  = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic          pixel;
    logic          underrun;
    logic          aux_ack;
    logic [DW-1:0] aux_data;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q    = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    charset_fetch #(.AW(AW), .DW(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .vid_req  (vid_req),
        .vid_code (vid_code),
        .vid_row  (vid_row),
        .vid_bank (vid_bank),
        .vid_inv  (vid_inv),
        .vid_load (vid_load),
        .pixel    (pixel),
        .underrun (underrun),
        .aux_req  (aux_req),
        .aux_addr (aux_addr),
        .aux_ack  (aux_ack),
        .aux_data (aux_data),
        .rom_addr (rom_addr),
        .rom_q    (rom_q)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data for the address presented in a cycle appears after the next edge.
    always @(posedge clock) rom_q <= mem[rom_addr];

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int         due;
        logic [7:0] pat;
    } cap_t;

    cap_t          vq[$];
    int            mk;
    logic [7:0]    m_sr;
    logic [7:0]    m_pend;
    logic          m_pv;
    logic          m_unr;
    logic          m_ack;
    logic [7:0]    m_aux_data;
    logic [7:0]    aux_exp;
    logic          aux_out;
    int            aux_ack_edge;
    int            aux_free_edge;
    logic [AW-1:0] m_rom_addr;

    function automatic logic [7:0] pattern_of(logic [1:0] b, logic [7:0] c, logic [2:0] r, logic inv);
        logic [AW-1:0] a;
        a = {b, c, r};
        return mem[a] ^ (inv ? 8'hFF : 8'h00);
    endfunction

    task automatic model_reset();
        vq.delete();
        mk            = 0;
        m_sr          = '0;
        m_pend        = '0;
        m_pv          = 1'b0;
        m_unr         = 1'b0;
        m_ack         = 1'b0;
        m_aux_data    = '0;
        aux_exp       = '0;
        aux_out       = 1'b0;
        aux_ack_edge  = 0;
        aux_free_edge = 0;
        m_rom_addr    = '0;
    endtask

    // Advance the model by one clock edge using the inputs that were stable at that edge.
    task automatic model_edge();
        logic       cap;
        logic [7:0] cpat;
        cap_t       c;
        mk++;
        cap  = 1'b0;
        cpat = '0;
        if (vq.size() > 0 && vq[0].due == mk) begin
            cap  = 1'b1;
            cpat = vq[0].pat;
            void'(vq.pop_front());
        end
        if (vid_req) begin
            c.due = mk + 2;
            c.pat = pattern_of(vid_bank, vid_code, vid_row, vid_inv);
            vq.push_back(c);
            m_rom_addr = {vid_bank, vid_code, vid_row};
        end
        m_ack = 1'b0;
        if (aux_out && mk == aux_ack_edge) begin
            m_ack         = 1'b1;
            m_aux_data    = aux_exp;
            aux_out       = 1'b0;
            aux_free_edge = mk + 2;
        end
        if (!vid_req && aux_req && !aux_out && mk >= aux_free_edge) begin
            aux_out      = 1'b1;
            aux_ack_edge = mk + 2;
            aux_exp      = mem[aux_addr];
            m_rom_addr   = aux_addr;
        end
        if (ce && vid_load) begin
            if (cap) begin
                m_sr = cpat;
            end else if (m_pv) begin
                m_sr = m_pend;
            end else begin
                m_sr  = '0;
                m_unr = 1'b1;
            end
            m_pv = 1'b0;
        end else begin
            if (ce) m_sr = {m_sr[6:0], 1'b0};
            if (cap) begin
                m_pend = cpat;
                m_pv   = 1'b1;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
        chk("pixel",    32'(pixel),    32'(m_sr[7]));
        chk("underrun", 32'(underrun), 32'(m_unr));
        chk("aux_ack",  32'(aux_ack),  32'(m_ack));
        chk("aux_data", 32'(aux_data), 32'(m_aux_data));
        chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        vid_req  = 1'b0;
        vid_load = 1'b0;
        vid_inv  = 1'b0;
        ce       = 1'b0;
        aux_req  = 1'b0;
        #1;
        chk("rst_pixel",    32'(pixel),    32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_aux_ack",  32'(aux_ack),  32'd0);
        chk("rst_aux_data", 32'(aux_data), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]    bits;
        logic [4:0]    seq5;
        logic [AW-1:0] a;
        int            ackpos;
        int            nack;
        int            ack1;
        int            ack2;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        mem[13'h0A0B] = 8'hA5;
        mem[13'h1FFF] = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            a      = {2'd2, 8'h10 + 8'(i), 3'd0};
            mem[a] = {(i % 2 == 0), 7'($urandom)};
        end
        model_reset();

        #2;
        do_reset();

        // Video fetch: code 0x41, row 3, bank 1 -> address 0x0A0B, pattern 0xA5.
        vid_code = 8'h41; vid_row = 3'd3; vid_bank = 2'd1; vid_inv = 1'b0; vid_req = 1'b1;
        step();
        chk("vid_rom_addr", 32'(rom_addr), 32'h0A0B);
        vid_req = 1'b0;
        step();
        step();
        vid_load = 1'b1; ce = 1'b1;
        step();
        bits = '0;
        bits[7] = pixel;
        ce = 1'b0;
        step();
        chk("ce_low_hold", 32'(pixel), 32'd1);
        vid_load = 1'b0; ce = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            step();
            bits[i] = pixel;
        end
        ce = 1'b0;
        chk("vid_seq_a5", 32'(bits), 32'hA5);

        // Inverted fetch loaded on the capture edge (bypass) -> 0x5A, no underrun.
        vid_inv = 1'b1; vid_req = 1'b1;
        step();
        vid_req = 1'b0; vid_inv = 1'b0;
        step();
        vid_load = 1'b1; ce = 1'b1;
        step();
        chk("bypass_underrun", 32'(underrun), 32'd0);
        bits = '0;
        bits[7] = pixel;
        vid_load = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            step();
            bits[i] = pixel;
        end
        chk("vid_seq_5a", 32'(bits), 32'h5A);

        // Bypass then immediate second load: pattern consumed, so sr clears and underrun sticks.
        vid_inv = 1'b1; vid_req = 1'b1; vid_load = 1'b0; ce = 1'b0;
        step();
        vid_req = 1'b0; vid_inv = 1'b0;
        step();
        vid_load = 1'b1; ce = 1'b1;
        step();
        chk("bypass2_pixel", 32'(pixel), 32'd0);
        step();
        chk("underrun_set", 32'(underrun), 32'd1);
        chk("underrun_sr0", 32'(pixel), 32'd0);
        vid_load = 1'b0;
        repeat (3) step();
        chk("underrun_sticky", 32'(underrun), 32'd1);
        ce = 1'b0;

        // Reset mid-fetch: video and aux both in flight; both are discarded.
        vid_code = 8'h41; vid_row = 3'd3; vid_bank = 2'd1; vid_req = 1'b1;
        step();
        vid_req = 1'b0; aux_addr = 13'h1FFF; aux_req = 1'b1;
        step();
        do_reset();
        nack = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (aux_ack) nack++;
        end
        chk("rst_no_ack", 32'(nack), 32'd0);
        vid_load = 1'b1; ce = 1'b1;
        step();
        chk("rst_pend_dropped", 32'(underrun), 32'd1);
        vid_load = 1'b0; ce = 1'b0;
        do_reset();

        // Aux uncontended.
        aux_addr = 13'h1FFF; aux_req = 1'b1;
        step();
        chk("aux_rom_addr", 32'(rom_addr), 32'h1FFF);
        step();
        chk("aux_ack_early", 32'(aux_ack), 32'd0);
        step();
        chk("aux_ack_pulse", 32'(aux_ack), 32'd1);
        chk("aux_data_3c",   32'(aux_data), 32'h3C);
        aux_req = 1'b0;
        step();
        chk("aux_ack_single", 32'(aux_ack), 32'd0);
        chk("aux_data_held",  32'(aux_data), 32'h3C);

        // Contention: five back-to-back video requests hold off a pending aux read.
        aux_addr = 13'h0123; aux_req = 1'b1;
        seq5 = '0;
        ackpos = -1;
        for (int j = 0; j < 8; j++) begin
            vid_req  = (j < 5);
            vid_code = 8'h10 + 8'(j); vid_bank = 2'd2; vid_row = 3'd0; vid_inv = 1'b0;
            ce       = (j >= 2 && j <= 6);
            vid_load = ce;
            step();
            if (j >= 2 && j <= 6) seq5 = {seq5[3:0], pixel};
            if (j == 5) chk("cont_aux_issue", 32'(rom_addr), 32'h0123);
            if (aux_ack && ackpos < 0) ackpos = j;
        end
        vid_req = 1'b0; ce = 1'b0; vid_load = 1'b0; aux_req = 1'b0;
        chk("cont_ack_pos",  32'(ackpos),   32'd7);
        chk("cont_vid_order", 32'(seq5),    32'b10101);
        chk("cont_aux_data", 32'(aux_data), 32'(mem[13'h0123]));
        repeat (2) step();

        // Back-to-back aux with the request held high through the ack.
        aux_addr = 13'h0F0F; aux_req = 1'b1;
        nack = 0; ack1 = -1; ack2 = -1;
        for (int j = 0; j < 12; j++) begin
            step();
            if (j == 3) chk("b2b_hold",   32'(rom_addr), 32'h0F0F);
            if (j == 4) chk("b2b_issue2", 32'(rom_addr), 32'h0555);
            if (aux_ack) begin
                nack++;
                if (nack == 1) begin
                    ack1 = j;
                    aux_addr = 13'h0555;
                end else begin
                    ack2 = j;
                    aux_req = 1'b0;
                end
            end
        end
        chk("b2b_ack1",  32'(ack1), 32'd2);
        chk("b2b_ack2",  32'(ack2), 32'd6);
        chk("b2b_count", 32'(nack), 32'd2);
        chk("b2b_data",  32'(aux_data), 32'(mem[13'h0555]));

        // Randomized traffic with periodic asynchronous resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999) do_reset();
            vid_req  = ($urandom_range(0, 99) < 40);
            vid_code = 8'($urandom);
            vid_row  = 3'($urandom);
            vid_bank = 2'($urandom);
            vid_inv  = 1'($urandom_range(0, 1));
            ce       = ($urandom_range(0, 99) < 70);
            vid_load = ($urandom_range(0, 99) < 12);
            if (!aux_req) begin
                if ($urandom_range(0, 99) < 30) begin
                    aux_req  = 1'b1;
                    aux_addr = 13'($urandom);
                end
            end else if (m_ack) begin
                if ($urandom_range(0, 1) == 1) aux_addr = 13'($urandom);
                else aux_req = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
